mul_share_arbiter: RTL and testbench
====================================

# mul_share_arbiter

Shares one iterative shift-add 16x16 multiplier among several requesters. Arbitrates pending requests, captures the winner's operands, and runs the multiplication over DATA_WIDTH cycles. It then returns the 2·DATA_WIDTH-bit product with a one-cycle done pulse. It sits beside the ALU datapath so MUL-class work can use one small sequential multiplier instead of a combinational multiplier per client.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 16: operand width; the product is 2·DATA_WIDTH.
- Clock  in  1  single clock; all state on posedge.
- Reset  in  1  asynchronous, active-low; clears all state immediately.
- iRequest  in  NUM_REQ  per-requester request level.
- iDato_A  in  NUM_REQ·DATA_WIDTH  packed multiplicands; requester i at [i·DATA_WIDTH +: DATA_WIDTH].
- iDato_B  in  NUM_REQ·DATA_WIDTH  packed multipliers, same packing.
- oGrant  out  NUM_REQ  one-hot owner of the multiplier during an operation.
- oBusy  out  1  high while an operation is in progress.
- oDone  out  NUM_REQ  one-hot, one-cycle pulse to the owner when oResult is valid.
- oResult  out  2·DATA_WIDTH  last product; holds until the next completion.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - If any iRequest bit is high, the arbiter picks a winner.
  - At the clock edge: latch that requester's A and B, set oGrant, clear the product accumulator, clear the step counter, go to RUN.
  - With no request, stay in IDLE.
- RUN, one step per cycle:
  - If B[0]=1, add A to the upper half of the (2·DATA_WIDTH+1)-bit accumulator.
  - Shift the accumulator right by 1 and shift B right by 1.
  - The step counter counts 0..DATA_WIDTH-1. After step DATA_WIDTH-1, write oResult and go to DONE.
- DONE: drive oDone at the granted index for one cycle, then return to IDLE and clear oGrant and oBusy at that edge.
- Arithmetic:
  - Unsigned only. The product is exact; overflow is impossible.
  - Zero operands still take the full DATA_WIDTH steps, so latency is fixed.
- Handshake:
  - Requests cannot be cancelled. If the owner drops iRequest mid-operation, the operation still completes and pulses oDone.
  - A requester must drop iRequest in its oDone cycle. If it is still high in the following IDLE cycle, it is a new request.
  - Operand inputs are ignored after capture.
- Requests arriving in RUN or DONE are not lost. They are arbitrated in the next IDLE cycle if still held.
- Reset asserted mid-operation:
  - All state is cleared asynchronously.
  - No oDone is issued for the aborted operation, and oResult becomes 0.
- Reset values: oGrant=0, oBusy=0, oDone=0, oResult=0, state=IDLE, round-robin pointer=NUM_REQ-1 (so requester 0 wins first).

## Timing
- Request sampled high in IDLE cycle c:
  - oGrant and oBusy are high in cycles c+1 through c+DATA_WIDTH+1.
  - oDone and the new oResult appear in cycle c+DATA_WIDTH+1.
  - IDLE again in cycle c+DATA_WIDTH+2.
- Latency is DATA_WIDTH+1 cycles (17 at default). Back-to-back throughput is one operation per DATA_WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MUL_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - The search starts at the index after the last granted requester and wraps at NUM_REQ-1 → 0.
  - The pointer updates only at grant.
- Not defined: fixed priority, lowest index wins. The pointer register is not built.

## Structure
- Shared package mul_arb_pkg holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - default NUM_REQ and DATA_WIDTH constants
  - step-counter width, $clog2(DATA_WIDTH).
- One sub-module, rr_arbiter:
  - inputs: request vector and pointer
  - outputs: one-hot winner and winner index
  - also contains the fixed-priority path selected by the macro.
- The top level holds the FSM, operand and accumulator registers, and output registers.

## Test plan
- Reset=0 held for 3 cycles with requests active → all outputs 0, no grant. Release → requester 0 granted next edge.
- Requester 2 alone, A=3, B=5 → oGrant=0100 one cycle later, oDone=0100 exactly 17 cycles after request, oResult=32'd15.
- Requester 1, A=B=16'hFFFF → oResult=32'hFFFE0001. Then A=0, B=16'h1234 → oResult=0, still 17-cycle latency.
- All four requesting continuously, round-robin:
  - With MUL_ARB_ROUND_ROBIN_EN: grant order 0,1,2,3,0, one oDone per 18 cycles.
  - Without the macro: requester 0 wins every time.
- Reset asserted in the 8th RUN cycle → oGrant, oBusy, oResult drop to 0 asynchronously. After release, no oDone for the aborted operation.
- Requester 3 raises iRequest during requester 0's DONE cycle → requester 3 granted in the cycle after IDLE sampling. Requester 0's oDone is delivered exactly once.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg
// Shared definitions for the shared-multiplier arbiter slice.
//   state_t             : FSM encoding (IDLE, RUN, DONE)
//   DEFAULT_NUM_REQ     : default requester count
//   DEFAULT_DATA_WIDTH  : default operand width
//   stepWidth()         : width of the step counter for a given operand width
//   STEP_WIDTH          : step counter width at the default operand width
package mul_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_NUM_REQ    = 4;
   localparam int DEFAULT_DATA_WIDTH = 16;

   // The step counter only has to reach DATA_WIDTH-1, so $clog2 is enough;
   // the floor of 1 keeps a degenerate 1-bit operand width legal.
   function automatic int stepWidth(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   localparam int STEP_WIDTH = stepWidth(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// rr_arbiter
// Picks one winner from a request vector. Purely combinational.
//   request   : per-requester request level
//   pointer   : index of the last granted requester
//   winner    : one-hot winner (all zero when nothing is requested)
//   winnerIdx : binary index of the winner
// Build option MUL_ARB_ROUND_ROBIN_EN: when defined, the search starts one
// past the pointer and wraps; otherwise the lowest index wins and the
// pointer is ignored.
module rr_arbiter
   import mul_arb_pkg::*;
#(
   parameter int NUM_REQ = DEFAULT_NUM_REQ,
   parameter int IDX_W   = $clog2(DEFAULT_NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] request,
   input  logic [IDX_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] winner,
   output logic [IDX_W-1:0]   winnerIdx
);

`ifdef MUL_ARB_ROUND_ROBIN_EN
   // Walk the requesters starting right after the previous owner so that
   // every continuously requesting client gets a turn.
   always_comb begin
      int idx;
      logic found;
      winner    = '0;
      winnerIdx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(pointer) + k) % NUM_REQ;
         if (!found && request[idx]) begin
            winner[idx] = 1'b1;
            winnerIdx   = IDX_W'(idx);
            found       = 1'b1;
         end
      end
   end
`else
   logic unusedPointer;
   assign unusedPointer = ^pointer;

   // Fixed priority: the lowest requesting index wins.
   always_comb begin
      logic found;
      winner    = '0;
      winnerIdx = '0;
      found     = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && request[k]) begin
            winner[k] = 1'b1;
            winnerIdx = IDX_W'(k);
            found     = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
// One iterative shift-add multiplier shared among NUM_REQ requesters.
//   clk      : clock, all state on the rising edge
//   rst_n    : asynchronous active-low reset
//   iRequest : per-requester request level
//   iDato_A  : packed multiplicands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   iDato_B  : packed multipliers, same packing
//   oGrant   : one-hot owner while an operation is in progress
//   oBusy    : high while an operation is in progress
//   oDone    : one-cycle one-hot pulse to the owner when oResult is valid
//   oResult  : last product, held until the next completion
// Build option MUL_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the lowest requesting index always wins.
module mul_share_arbiter
   import mul_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEFAULT_NUM_REQ,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            iRequest,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] iDato_A,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] iDato_B,
   output logic [NUM_REQ-1:0]            oGrant,
   output logic                          oBusy,
   output logic [NUM_REQ-1:0]            oDone,
   output logic [2*DATA_WIDTH-1:0]       oResult
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = stepWidth(DATA_WIDTH);

   state_t                    state;
   state_t                    nextState;
   logic [NUM_REQ-1:0]        grantReg;
   logic                      busyReg;
   logic [NUM_REQ-1:0]        doneReg;
   logic [2*DATA_WIDTH-1:0]   resultReg;
   logic [DATA_WIDTH-1:0]     opA;
   logic [DATA_WIDTH-1:0]     opB;
   logic [2*DATA_WIDTH:0]     acc;
   logic [CNT_W-1:0]          stepCnt;
   logic [NUM_REQ-1:0]        reqWinner;
   logic [IDX_W-1:0]          reqWinnerIdx;
   logic [IDX_W-1:0]          rrPointer;
   logic                      anyRequest;
   logic                      lastStep;
   logic [DATA_WIDTH-1:0]     addend;
   logic [DATA_WIDTH:0]       upperSum;
   logic [2*DATA_WIDTH:0]     accNext;

   assign anyRequest = |iRequest;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) uArbiter (
      .request   (iRequest),
      .pointer   (rrPointer),
      .winner    (reqWinner),
      .winnerIdx (reqWinnerIdx)
   );

`ifdef MUL_ARB_ROUND_ROBIN_EN
   // The pointer remembers the last owner and moves only when a grant is
   // made; resetting it to the top index makes requester 0 win first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rrPointer <= IDX_W'(NUM_REQ - 1);
      end else if (state == IDLE && anyRequest) begin
         rrPointer <= reqWinnerIdx;
      end
   end
`else
   assign rrPointer = '0;
`endif

   // One shift-add step: conditionally add A into the upper half, then
   // shift everything right. The extra top bit of the accumulator catches
   // the carry of the add before the shift brings it back into range.
   assign addend   = opB[0] ? opA : '0;
   assign upperSum = acc[2*DATA_WIDTH:DATA_WIDTH] + {1'b0, addend};
   assign accNext  = {upperSum, acc[DATA_WIDTH-1:0]} >> 1;
   assign lastStep = (state == RUN) && (stepCnt == CNT_W'(DATA_WIDTH - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: a request in IDLE starts a fixed-length run, and
   // DONE always lasts exactly one cycle.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (anyRequest) nextState = RUN;
         RUN:     if (lastStep)   nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Datapath and output registers. Operands are captured only at grant,
   // so later changes on the input buses cannot disturb the operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grantReg  <= '0;
         busyReg   <= 1'b0;
         doneReg   <= '0;
         resultReg <= '0;
         opA       <= '0;
         opB       <= '0;
         acc       <= '0;
         stepCnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (anyRequest) begin
                  opA      <= iDato_A[reqWinnerIdx*DATA_WIDTH +: DATA_WIDTH];
                  opB      <= iDato_B[reqWinnerIdx*DATA_WIDTH +: DATA_WIDTH];
                  acc      <= '0;
                  stepCnt  <= '0;
                  grantReg <= reqWinner;
                  busyReg  <= 1'b1;
               end
            end
            RUN: begin
               acc     <= accNext;
               opB     <= opB >> 1;
               stepCnt <= stepCnt + CNT_W'(1);
               if (lastStep) begin
                  resultReg <= accNext[2*DATA_WIDTH-1:0];
                  doneReg   <= grantReg;
               end
            end
            DONE: begin
               doneReg  <= '0;
               grantReg <= '0;
               busyReg  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign oGrant  = grantReg;
   assign oBusy   = busyReg;
   assign oDone   = doneReg;
   assign oResult = resultReg;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
// Self-checking bench for mul_share_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (owner, elapsed cycles, exact product A*B).
// Honours MUL_ARB_ROUND_ROBIN_EN in the model's winner selection.
module tb_mul_share_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DW      = 16;
   localparam int LAT     = DW + 1;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NUM_REQ-1:0]     iRequest = '0;
   logic [NUM_REQ*DW-1:0]  iDato_A = '0;
   logic [NUM_REQ*DW-1:0]  iDato_B = '0;
   logic [NUM_REQ-1:0]     oGrant;
   logic                   oBusy;
   logic [NUM_REQ-1:0]     oDone;
   logic [2*DW-1:0]        oResult;

   int assertCount = 0;
   int failCount   = 0;
   bit checkEn     = 1'b0;

   mul_share_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .iRequest (iRequest),
      .iDato_A  (iDato_A),
      .iDato_B  (iDato_B),
      .oGrant   (oGrant),
      .oBusy    (oBusy),
      .oDone    (oDone),
      .oResult  (oResult)
   );

   always #5 clk = ~clk;

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one requester's operands and request level.
   task automatic applyStimulus(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic req);
      iDato_A[idx*DW +: DW] = a;
      iDato_B[idx*DW +: DW] = b;
      iRequest[idx]         = req;
   endtask

   // ---------------- behavioural model ----------------
   bit          mBusy   = 1'b0;
   int          mOwner  = 0;
   int          mCycle  = 0;
   logic [31:0] mProd   = '0;
   logic [31:0] mResult = '0;
   int          mPtr    = NUM_REQ - 1;
   int          mWin;

   function automatic int pickWinner(input logic [NUM_REQ-1:0] req, input int ptr);
`ifdef MUL_ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (req[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
`else
      for (int k = 0; k < NUM_REQ; k++) begin
         if (req[k]) return k;
      end
      if (ptr < 0) return -2;
`endif
      return -1;
   endfunction

   always_comb mWin = pickWinner(iRequest, mPtr);

   // mCycle counts cycles since grant: 1..LAT, with the done pulse at LAT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mBusy   <= 1'b0;
         mCycle  <= 0;
         mResult <= '0;
         mPtr    <= NUM_REQ - 1;
      end else if (!mBusy) begin
         if (mWin >= 0) begin
            mBusy  <= 1'b1;
            mOwner <= mWin;
            mCycle <= 1;
            mProd  <= 32'(iDato_A[mWin*DW +: DW]) * 32'(iDato_B[mWin*DW +: DW]);
            mPtr   <= mWin;
         end
      end else if (mCycle == LAT) begin
         mBusy <= 1'b0;
      end else begin
         mCycle <= mCycle + 1;
         if (mCycle == LAT - 1) mResult <= mProd;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("grant",  64'(oGrant),  64'(mBusy ? (4'b1 << mOwner) : 4'b0));
         checkOutput("busy",   64'(oBusy),   64'(mBusy));
         checkOutput("done",   64'(oDone),   64'((mBusy && mCycle == LAT) ? (4'b1 << mOwner) : 4'b0));
         checkOutput("result", 64'(oResult), 64'(mResult));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic waitIdle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (oBusy && n < 60);
      checkOutput("waitIdle", 64'(oBusy), 64'(0));
   endtask

   task automatic doOp(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [31:0] expRes, input string name);
      int n = 0;
      bit got = 1'b0;
      waitIdle();
      @(posedge clk);
      #2;
      applyStimulus(idx, a, b, 1'b1);
      while (!got && n < 40) begin
         @(posedge clk);
         n++;
         #2;
         if (n == 1) begin
            checkOutput("grantOneHot", 64'(oGrant), 64'(4'b1 << idx));
            iRequest = '0;
         end
         @(negedge clk);
         if (oDone != 0) got = 1'b1;
      end
      checkOutput("latency", 64'(n), 64'(LAT));
      checkOutput("doneOneHot", 64'(oDone), 64'(4'b1 << idx));
      checkOutput(name, 64'(oResult), 64'(expRes));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cyc;
      int k;
      int done0Count;
      logic [NUM_REQ-1:0] order [5];
      int when [5];

      // Reset held with all requests active: nothing may be granted.
      iRequest = 4'hF;
      for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, DW'(i + 1), DW'(i + 1), 1'b1);
      @(posedge clk);
      checkEn = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("rstGrant",  64'(oGrant),  64'(0));
      checkOutput("rstBusy",   64'(oBusy),   64'(0));
      checkOutput("rstDone",   64'(oDone),   64'(0));
      checkOutput("rstResult", 64'(oResult), 64'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      checkOutput("firstGrant", 64'(oGrant), 64'(4'b0001));
      iRequest = '0;

      // Single-requester products with literal expectations.
      doOp(2, 16'd3, 16'd5, 32'd15, "prod3x5");
      doOp(1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "prodMax");
      doOp(1, 16'h0000, 16'h1234, 32'h0, "prodZero");

      // All requesters held: grant order depends on the arbitration mode.
      waitIdle();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, DW'(i + 2), DW'(i + 3), 1'b1);
      cyc = 0;
      k = 0;
      while (k < 5 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (oDone != 0) begin
            order[k] = oDone;
            when[k]  = cyc;
            k++;
         end
      end
      #1;
      iRequest = '0;
      checkOutput("rrCount", 64'(k), 64'(5));
      for (int i = 0; i < 5; i++) begin
`ifdef MUL_ARB_ROUND_ROBIN_EN
         checkOutput("rrOrder", 64'(order[i]), 64'(4'b1 << (i % NUM_REQ)));
`else
         checkOutput("fixedOrder", 64'(order[i]), 64'(4'b0001));
`endif
         if (i > 0) checkOutput("rrSpacing", 64'(when[i] - when[i-1]), 64'(LAT + 1));
      end

      // Reset during the 8th RUN cycle aborts the operation silently.
      waitIdle();
      @(posedge clk);
      #2;
      applyStimulus(1, 16'd7, 16'd9, 1'b1);
      @(posedge clk);
      #2;
      iRequest = '0;
      repeat (7) @(posedge clk);
      #2;
      checkOutput("preAbortBusy", 64'(oBusy), 64'(1));
      rst_n = 1'b0;
      #1;
      checkOutput("abortGrant",  64'(oGrant),  64'(0));
      checkOutput("abortBusy",   64'(oBusy),   64'(0));
      checkOutput("abortResult", 64'(oResult), 64'(0));
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         checkOutput("noAbortDone", 64'(oDone), 64'(0));
      end

      // Requester 3 arrives during requester 0's DONE cycle.
      @(posedge clk);
      #2;
      applyStimulus(0, 16'd11, 16'd13, 1'b1);
      cyc = 0;
      done0Count = 0;
      while (done0Count == 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (oDone[0]) done0Count++;
      end
      checkOutput("req0Result", 64'(oResult), 64'(143));
      #1;
      iRequest = '0;
      applyStimulus(3, 16'd5, 16'd6, 1'b1);
      @(posedge clk);
      #2;
      checkOutput("idleAfterDone", 64'(oBusy), 64'(0));
      @(posedge clk);
      #2;
      checkOutput("req3Grant", 64'(oGrant), 64'(4'b1000));
      iRequest = '0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (oDone[0]) done0Count++;
      end
      checkOutput("req0DoneOnce", 64'(done0Count), 64'(1));
      checkOutput("req3Result", 64'(oResult), 64'(30));

      // Randomized traffic, checked each cycle by the model.
      waitIdle();
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk);
         #2;
         iDato_A  = {$urandom, $urandom};
         iDato_B  = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) begin
            iDato_A[15:0] = DW'($urandom_range(0, 3));
            iDato_B[15:0] = 16'hFFFF;
         end
         iRequest = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      end
      iRequest = '0;
      waitIdle();
      @(negedge clk);
      checkEn = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
